rr_mux4_arbiter: RTL and testbench

//  Round-robin arbiter that shares one 4-to-1 single-bit mux datapath among four requesters.
//  - Each requester i raises req[i] and places its data bit on W[i].
//  - The arbiter owns the mux select lines and grants the path to one requester at a time.
//  - It registers the selected bit as dout/dout_valid for the downstream consumer.
//  - Sits between the requester bank and the mux4to1 datapath; it is the only driver of S.

---
 rtl/rr_mux4_arbiter_pkg.sv | 23 ++
 rtl/mux4to1.sv | 14 +
 rtl/rr_pick4.sv | 31 +++
 rtl/rr_mux4_arbiter.sv | 150 +++++++++++++++
 tb/tb_rr_mux4_arbiter.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/rr_mux4_arbiter_pkg.sv
// rr_mux4_arbiter_pkg: shared sizes, state encoding and grant helper for the round-robin mux arbiter.
`default_nettype none

package rr_mux4_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux4to1.sv
// mux4to1: single-bit 4-to-1 mux; w_i[0] is the leftmost bit and is selected by s_i=2'b00.
`default_nettype none

module mux4to1 (
    input  logic [0:3] w_i,
    input  logic [1:0] s_i,
    output logic       f_o
);

    assign f_o = w_i[s_i];

endmodule

`default_nettype wire

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin pick; searches last+1, last+2, last+3, last (mod 4).
`default_nettype none

module rr_pick4
    import rr_mux4_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] last_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Walk downward so the closest candidate after last is the final writer.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = last_i + SEL_W'(k);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter: round-robin owner of a shared 4-to-1 mux with registered output.
// Optional per-owner burst limit enabled by defining MUX_ARB_BURST_LIMIT_EN.
`default_nettype none

module rr_mux4_arbiter
    import rr_mux4_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [0:N_REQ-1] w_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             busy_o,
    output logic             dout_o,
    output logic             dout_valid_o
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             busy_q, busy_d;
    logic             dout_q, dout_d;
    logic             dv_q, dv_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             mux_f;
    logic             take;

    // The owner is masked out so a forced handover never re-picks it.
    rr_pick4 u_pick (
        .req_i   (req_i & ~gnt_q),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    mux4to1 u_mux (
        .w_i (w_i),
        .s_i (sel_q),
        .f_o (mux_f)
    );

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int CNT_W = (MAX_BURST > 4) ? $clog2(MAX_BURST) : 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_max_burst;
    assign unused_max_burst = (MAX_BURST > 0);
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        busy_d  = busy_q;
        dout_d  = busy_q ? mux_f : dout_q;
        dv_d    = busy_q;
        take    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take = pick_found;
            end
            ST_GRANT: begin
                if (!req_i[sel_q]) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end
`ifdef MUX_ARB_BURST_LIMIT_EN
                else if (cnt_q == CNT_MAX && pick_found) begin
                    take = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (take) begin
            state_d = ST_GRANT;
            sel_d   = pick_idx;
            gnt_d   = onehot4(pick_idx);
            last_d  = pick_idx;
            busy_d  = 1'b1;
        end
    end

`ifdef MUX_ARB_BURST_LIMIT_EN
    always_comb begin
        cnt_d = cnt_q;
        if (take || state_d == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= 2'd3;
            busy_q  <= 1'b0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign sel_o        = sel_q;
    assign busy_o       = busy_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = dv_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux4_arbiter.sv
// tb_rr_mux4_arbiter: directed checks of reset, rotation, handover, burst behaviour and mid-grant reset.
`default_nettype none

module tb_rr_mux4_arbiter;

    logic       clk;
    logic       resetn;
    logic [3:0] req;
    logic [0:3] w;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       dout;
    logic       dout_valid;

    int checks = 0;
    int errors = 0;

    rr_mux4_arbiter #(.MAX_BURST(4)) dut (
        .clk_i        (clk),
        .resetn_i     (resetn),
        .req_i        (req),
        .w_i          (w),
        .gnt_o        (gnt),
        .sel_o        (sel),
        .busy_o       (busy),
        .dout_o       (dout),
        .dout_valid_o (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [3:0] eg, input logic [1:0] es,
                               input logic eb);
        check({tag, "_gnt"}, {4'b0, gnt}, {4'b0, eg});
        check({tag, "_sel"}, {6'b0, sel}, {6'b0, es});
        check({tag, "_busy"}, {7'b0, busy}, {7'b0, eb});
    endtask

    task automatic check_dout(input string tag, input logic ed, input logic ev);
        check({tag, "_dout"}, {7'b0, dout}, {7'b0, ed});
        check({tag, "_dv"}, {7'b0, dout_valid}, {7'b0, ev});
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [1:0] exp_s;

        // Reset held with every request high.
        resetn = 1'b0;
        req    = 4'b1111;
        w      = 4'b1111;
        #1;
        check_grant("rst_async", 4'b0000, 2'd0, 1'b0);
        check_dout("rst_async", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_grant("rst_hold", 4'b0000, 2'd0, 1'b0);
            check_dout("rst_hold", 1'b0, 1'b0);
        end

        // Single request from requester 0.
        req    = 4'b0001;
        w      = 4'b1000;
        resetn = 1'b1;
        @(negedge clk);
        check_grant("single", 4'b0001, 2'd0, 1'b1);
        check_dout("single_pre", 1'b0, 1'b0);
        @(negedge clk);
        check_dout("single_out", 1'b1, 1'b1);

        // Rotation: each owner drops req for one cycle, others keep requesting.
        w = 4'b1010;
        req = 4'b1110;
        @(negedge clk);
        check_grant("rot1", 4'b0010, 2'd1, 1'b1);
        check_dout("rot1", 1'b1, 1'b1);
        req = 4'b1101;
        @(negedge clk);
        check_grant("rot2", 4'b0100, 2'd2, 1'b1);
        check_dout("rot2", 1'b0, 1'b1);
        req = 4'b1011;
        @(negedge clk);
        check_grant("rot3", 4'b1000, 2'd3, 1'b1);
        check_dout("rot3", 1'b1, 1'b1);
        req = 4'b0111;
        @(negedge clk);
        check_grant("rot0", 4'b0001, 2'd0, 1'b1);
        check_dout("rot0", 1'b0, 1'b1);

        // Handover from owner 2 with requesters 0 and 3 waiting: 3 wins.
        req = 4'b0100;
        @(negedge clk);
        check_grant("ho_own2", 4'b0100, 2'd2, 1'b1);
        req = 4'b1001;
        @(negedge clk);
        check_grant("handover", 4'b1000, 2'd3, 1'b1);

        // Requesters 1 and 2 held; owner 3 drops so 1 wins first.
        req = 4'b0110;
        @(negedge clk);
        check_grant("burst_k0", 4'b0010, 2'd1, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
`ifdef MUX_ARB_BURST_LIMIT_EN
            exp_g = ((k / 4) % 2 == 1) ? 4'b0100 : 4'b0010;
            exp_s = ((k / 4) % 2 == 1) ? 2'd2 : 2'd1;
`else
            exp_g = 4'b0010;
            exp_s = 2'd1;
`endif
            check_grant($sformatf("burst_k%0d", k), exp_g, exp_s, 1'b1);
        end

        // Mid-grant reset while owner 3 holds the path.
        req = 4'b1000;
        @(negedge clk);
        check_grant("pre_rst3", 4'b1000, 2'd3, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check_grant("midrst", 4'b0000, 2'd0, 1'b0);
        check_dout("midrst", 1'b0, 1'b0);
        @(negedge clk);
        req    = 4'b1001;
        resetn = 1'b1;
        @(negedge clk);
        check_grant("post_rst", 4'b0001, 2'd0, 1'b1);

        // Release all requests: idle, dout kept, valid drops.
        w   = 4'b1000;
        req = 4'b0000;
        @(negedge clk);
        check_grant("idle", 4'b0000, 2'd0, 1'b0);
        check_dout("idle_last", 1'b1, 1'b1);
        w = 4'b0000;
        @(negedge clk);
        check_dout("idle_hold", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
